accum_led_ctrl: RTL
===================

Name: accum_led_ctrl

Overview:
- Hardware sequencer for the switch-accumulator function on the Nios II lab board.
- Debounces the synchronized KEY3 (add) and KEY2 (clear) pushbuttons. Adds the switch value into a WIDTH-bit accumulator once per press.
- Arbitrates the LED bank between the accumulator and a software-driven PIO value.
- Sits beside the SoC in the top level, after the per-key sync flops and before LEDG.

Parameters:
- WIDTH, 8, accumulator, switch and LED width.
- DB_CYCLES, 500000, debounce and release qualification length in Clk cycles (10 ms at 50 MHz); legal range 1 to 2^20-1.

Ports:
- Clk  in  1  system clock (CLOCK_50 domain).
- Reset_n  in  1  asynchronous active-low reset.
- Key_add_n  in  1  synchronized KEY3, active low.
- Key_clr_n  in  1  synchronized KEY2, active low.
- Sw  in  WIDTH  synchronized switch operand.
- Sel_sw  in  1  LED source select: 1 = software value, 0 = accumulator.
- Sw_led  in  WIDTH  software PIO LED value.
- Acc  out  WIDTH  accumulator value.
- Carry  out  1  sticky overflow flag.
- Busy  out  1  high whenever FSM is not IDLE.
- Done  out  1  one-cycle pulse after an add or clear is committed.
- Led  out  WIDTH  registered LED drive.

Behaviour:
- Reset (asynchronous, Reset_n low):
  - Acc=0, Carry=0, Led=0, Done=0, Busy=0, state=IDLE, debounce counter=0.
  - A reset asserted mid-operation aborts the operation immediately; no partial add survives.
- States: IDLE, DEBOUNCE, EXEC, WAIT_REL.
- IDLE:
  - If either key is low, latch op: clear if Key_clr_n is low (clear wins when both keys are low), otherwise add.
  - Zero the counter and go to DEBOUNCE.
- DEBOUNCE:
  - Counter increments each cycle while the latched key stays low.
  - If the latched key goes high before the counter reaches DB_CYCLES-1, return to IDLE with no action.
  - When the counter reaches DB_CYCLES-1 with the key still low, go to EXEC.
- EXEC (exactly 1 cycle):
  - Add: Acc <= Acc + Sw, modulo 2^WIDTH. Carry <= Carry | carry-out. Sw is sampled in this cycle.
  - Clear: Acc <= 0, Carry <= 0.
  - Next cycle: Done=1 for exactly one cycle and state=WAIT_REL.
- WAIT_REL:
  - Counter restarts whenever either key is low.
  - When both keys have been continuously high for DB_CYCLES cycles, return to IDLE.
  - This gives exactly one operation per press; holding a key never repeats the operation.
- Busy = (state != IDLE), registered together with the state.
- Led is registered with 1-cycle latency: Led <= Sel_sw ? Sw_led : Acc. Sel_sw may change at any time; the new source appears on the next edge.
- Acc is stable except in the EXEC cycle; software may read it at any time.
- Width rule: sum is computed at WIDTH+1 bits; the MSB is the carry-out; the low WIDTH bits are stored.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: an add whose WIDTH+1-bit sum exceeds 2^WIDTH-1 sets Acc = 2^WIDTH-1 (all ones) and sets Carry. Once Acc is all ones, further adds leave it unchanged.
- Not defined: wrap-around modulo 2^WIDTH as described in Behaviour.
- Clear behaviour is identical in both builds.

Test Plan:
- All tests use DB_CYCLES=4.
- Reset: Reset_n low 3 cycles -> Acc=0, Carry=0, Led=0, Busy=0, Done=0. Reset_n high, keys high 20 cycles -> all outputs remain 0.
- Single add: Sw=0x05, Key_add_n low 10 cycles then high -> exactly one Done pulse, Acc=0x05, Carry=0. Led=0x05 one cycle after the Acc update with Sel_sw=0. Busy drops 4 cycles after release.
- Bounce rejection: Key_add_n low 2 cycles, high 1, low 2, high -> no Done, Acc unchanged, FSM back in IDLE.
- Wrap/overflow: Acc=0xF0, Sw=0x20, one press:
  - Without macro -> Acc=0x10, Carry=1.
  - With ACC_SATURATE_EN -> Acc=0xFF, Carry=1.
  - A clear press afterwards -> Acc=0x00, Carry=0.
- Simultaneous keys: Key_add_n and Key_clr_n low on the same cycle with Acc=0x33 -> clear executes, Acc=0x00. Exactly one Done until both keys are high for 4 cycles.
- Arbitration and reset mid-op: Sel_sw=1, Sw_led=0xA5 -> Led=0xA5 next cycle. Reset_n pulsed low during DEBOUNCE -> state IDLE, Acc=0, no Done.

Source files
------------

// File: rtl/accum_led_ctrl.sv
// accum_led_ctrl: debounced switch accumulator with LED source arbitration.
// KEY3 (add) and KEY2 (clear) are debounced by a four-state sequencer.
// Each qualified press commits exactly one add or clear. The LED bank is
// registered from either the accumulator or a software PIO value.
// Optional build macro: ACC_SATURATE_EN selects a saturating add instead of
// a wrap-around add. Clear behaves the same in both builds.
module accum_led_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 500000
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Key_add_n,
    input  logic             Key_clr_n,
    input  logic [WIDTH-1:0] Sw,
    input  logic             Sel_sw,
    input  logic [WIDTH-1:0] Sw_led,
    output logic [WIDTH-1:0] Acc,
    output logic             Carry,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Led
);

    localparam int              CNT_W    = 20;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] EXEC     = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    logic [1:0]       state, state_nxt;
    logic             op_clr, op_clr_nxt;
    logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
    logic             key_sel_n;
    logic             any_key_low;
    logic [WIDTH:0]   add_res;

    // Returns {carry_out, stored_value}; the sum is formed at WIDTH+1 bits.
    function automatic logic [WIDTH:0] acc_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
`ifdef ACC_SATURATE_EN
        if (sum[WIDTH]) begin
            sum[WIDTH-1:0] = '1;
        end
`endif
        return sum;
    endfunction

    assign key_sel_n   = op_clr ? Key_clr_n : Key_add_n;
    assign any_key_low = !Key_add_n || !Key_clr_n;
    assign add_res     = acc_add(Acc, Sw);

    // Next-state, debounce counter and operation latch.
    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        op_clr_nxt = op_clr;
        case (state)
            IDLE: begin
                if (any_key_low) begin
                    // Clear has priority when both keys are pressed together.
                    op_clr_nxt = !Key_clr_n;
                    db_cnt_nxt = '0;
                    state_nxt  = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (key_sel_n) begin
                    state_nxt = IDLE;
                end else if (db_cnt == CNT_LAST) begin
                    state_nxt = EXEC;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            EXEC: begin
                db_cnt_nxt = '0;
                state_nxt  = WAIT_REL;
            end
            WAIT_REL: begin
                // Any low key restarts the release qualification window.
                if (any_key_low) begin
                    db_cnt_nxt = '0;
                end else if (db_cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                db_cnt_nxt = '0;
            end
        endcase
    end

    // Sequencer state, Busy and the one-cycle Done pulse.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            db_cnt <= '0;
            op_clr <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            db_cnt <= db_cnt_nxt;
            op_clr <= op_clr_nxt;
            Busy   <= (state_nxt != IDLE);
            Done   <= (state == EXEC);
        end
    end

    // Accumulator and sticky carry change only in the EXEC cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Acc   <= '0;
            Carry <= 1'b0;
        end else if (state == EXEC) begin
            if (op_clr) begin
                Acc   <= '0;
                Carry <= 1'b0;
            end else begin
                Acc   <= add_res[WIDTH-1:0];
                Carry <= Carry | add_res[WIDTH];
            end
        end
    end

    // Registered LED drive from the selected source.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Led <= '0;
        end else begin
            Led <= Sel_sw ? Sw_led : Acc;
        end
    end

endmodule
